i2s_audio_rx: RTL and testbench

I2S_AUDIO_RX -- requirements
Module: i2s_audio_rx

---
 rtl/i2s_audio_rx.sv | 121 ++++++++++++
 tb/tb_i2s_audio_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_rx.sv
// I2S receiver: oversamples bclk/lrclk/sdata in the clk domain and emits coherent
// left/right PCM pairs, with short-slot and bclk-stall detection.
module i2s_audio_rx #(
    parameter int audio_bits   = 16,
    parameter int timeout_bits = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  bclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [audio_bits-1:0] pcm_l,
    output logic [audio_bits-1:0] pcm_r,
    output logic                  pcm_valid,
    output logic                  frame_err,
    output logic                  locked
);
    localparam int CW = $clog2(audio_bits + 1);
    localparam logic [CW-1:0]           CNT_FULL = CW'(audio_bits);
    localparam logic [timeout_bits-1:0] WD_MAX   = '1;
    localparam logic [timeout_bits-1:0] WD_PRE   = {{(timeout_bits-1){1'b1}}, 1'b0};

    // bit 0 = bclk, bit 1 = lrclk, bit 2 = sdata
    logic [2:0]              r_sync1;
    logic [2:0]              r_sync2;
    logic                    r_bclk_prev;
    logic                    r_lr_prev;
    logic [CW-1:0]           r_cnt;
    logic [audio_bits-1:0]   r_sr;
    logic [audio_bits-1:0]   r_hold_l;
    logic                    r_left_fresh;
    logic                    r_locked;
    logic [timeout_bits-1:0] r_wd;
    logic [audio_bits-1:0]   r_pcm_l;
    logic [audio_bits-1:0]   r_pcm_r;
    logic                    r_pcm_valid;
    logic                    r_frame_err;

    logic                  w_edge;
    logic                  w_lr;
    logic                  w_sd;
    logic                  w_shift_en;
    logic                  w_boundary;
    logic                  w_full;
    logic [CW-1:0]         w_cnt_inc;
    logic [audio_bits-1:0] w_sr_shift;

    always_comb begin
        w_edge     = r_sync2[0] & ~r_bclk_prev;
        w_lr       = r_sync2[1];
        w_sd       = r_sync2[2];
        w_shift_en = (r_cnt < CNT_FULL);
        w_sr_shift = w_shift_en ? {r_sr[audio_bits-2:0], w_sd} : r_sr;
        w_cnt_inc  = w_shift_en ? (r_cnt + CW'(1)) : r_cnt;
        w_boundary = w_edge & (w_lr != r_lr_prev);
        // Full-word test uses the count after the boundary bit has been shifted in.
        w_full     = (w_cnt_inc == CNT_FULL);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_bclk_prev  <= 1'b0;
            r_lr_prev    <= 1'b0;
            r_cnt        <= CNT_FULL;
            r_sr         <= '0;
            r_hold_l     <= '0;
            r_left_fresh <= 1'b0;
            r_locked     <= 1'b0;
            r_wd         <= '0;
            r_pcm_l      <= '0;
            r_pcm_r      <= '0;
            r_pcm_valid  <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync1     <= {sdata, lrclk, bclk};
            r_sync2     <= r_sync1;
            r_bclk_prev <= r_sync2[0];
            r_pcm_valid <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_edge) begin
                r_wd  <= '0;
                r_sr  <= w_sr_shift;
                r_cnt <= w_cnt_inc;
                if (w_boundary) begin
                    r_cnt     <= '0;
                    r_lr_prev <= w_lr;
                    if (!r_locked) begin
                        // The word closed at the locking boundary is partial by definition.
                        r_locked <= 1'b1;
                    end else if (!w_full) begin
                        r_frame_err  <= 1'b1;
                        r_left_fresh <= 1'b0;
                    end else if (!r_lr_prev) begin
                        r_hold_l     <= w_sr_shift;
                        r_left_fresh <= 1'b1;
                    end else if (r_left_fresh) begin
                        r_pcm_l      <= r_hold_l;
                        r_pcm_r      <= w_sr_shift;
                        r_pcm_valid  <= 1'b1;
                        r_left_fresh <= 1'b0;
                    end
                end
            end else if (r_wd != WD_MAX) begin
                r_wd <= r_wd + timeout_bits'(1);
                if (r_wd == WD_PRE && r_locked) begin
                    r_locked     <= 1'b0;
                    r_left_fresh <= 1'b0;
                    r_frame_err  <= 1'b1;
                end
            end
        end
    end

    assign pcm_l     = r_pcm_l;
    assign pcm_r     = r_pcm_r;
    assign pcm_valid = r_pcm_valid;
    assign frame_err = r_frame_err;
    assign locked    = r_locked;
endmodule

// File: tb/tb_i2s_audio_rx.sv
// Bench for i2s_audio_rx: drives I2S slots at clk/4 and checks PCM pairs, errors
// and their exact latency against a slot-level reference model.
module tb_i2s_audio_rx;
    localparam int AB      = 16;
    localparam int TB      = 12;
    localparam int WD_FIRE = (1 << TB) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          bclk = 1'b0;
    logic          lrclk = 1'b0;
    logic          sdata = 1'b0;
    logic [AB-1:0] pcm_l;
    logic [AB-1:0] pcm_r;
    logic          pcm_valid;
    logic          frame_err;
    logic          locked;

    i2s_audio_rx #(.audio_bits(AB), .timeout_bits(TB)) dut (
        .clk(clk), .reset_n(reset_n), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .pcm_l(pcm_l), .pcm_r(pcm_r), .pcm_valid(pcm_valid),
        .frame_err(frame_err), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_err;
        logic [AB-1:0] l;
        logic [AB-1:0] r;
        int            cyc;
    } ev_t;

    ev_t  sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_count = 0;
    logic rst_q = 1'b0;

    always @(posedge clk) begin
        cyc_count <= cyc_count + 1;
        rst_q     <= reset_n;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc_count);
        end
    endtask

    function automatic logic [AB-1:0] trunc(input logic [31:0] w);
        return w[31 -: AB];
    endfunction

    // Reference model state, advanced once per slot close.
    bit            m_locked = 1'b0;
    bit            m_fresh = 1'b0;
    logic [AB-1:0] m_hold = '0;
    bit            next_ch = 1'b0;
    bit            prev_ch = 1'b0;
    int            prev_len = 0;
    int            prev_eff = 0;
    logic [31:0]   prev_word = '0;
    int            last_rise = 0;

    task automatic model_close(input int rise);
        ev_t ev;
        ev.is_err = 1'b0;
        ev.l      = '0;
        ev.r      = '0;
        ev.cyc    = rise + 2;
        if (!m_locked) begin
            m_locked = 1'b1;
        end else if (prev_eff < AB) begin
            ev.is_err = 1'b1;
            sb.push_back(ev);
            m_fresh = 1'b0;
        end else if (prev_ch == 1'b0) begin
            m_hold  = trunc(prev_word);
            m_fresh = 1'b1;
        end else if (m_fresh) begin
            ev.l = m_hold;
            ev.r = trunc(prev_word);
            sb.push_back(ev);
            m_fresh = 1'b0;
        end
    endtask

    // One slot: lrclk = channel for len bclk periods, data delayed by one bit.
    task automatic send_slot(input int len, input logic [31:0] word, input int reset_at);
        bit ch;
        int eff;
        ch      = next_ch;
        next_ch = ~next_ch;
        eff     = len;
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            bclk  = 1'b0;
            lrclk = ch;
            if (j == 0) sdata = (prev_len > 0) ? prev_word[32 - prev_len] : 1'b0;
            else        sdata = word[32 - j];
            if (j == reset_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                check_val("rst_pcm_l", pcm_l, 0);
                check_val("rst_pcm_r", pcm_r, 0);
                check_val("rst_valid", pcm_valid, 0);
                check_val("rst_err", frame_err, 0);
                check_val("rst_locked", locked, 0);
                reset_n  = 1'b1;
                m_locked = 1'b1;
                m_fresh  = 1'b0;
                eff      = len - j;
            end else begin
                @(negedge clk);
            end
            @(negedge clk);
            bclk      = 1'b1;
            last_rise = cyc_count + 1;
            if (j == 0 && prev_len > 0) model_close(last_rise);
            @(negedge clk);
        end
        prev_ch   = ch;
        prev_len  = len;
        prev_eff  = eff;
        prev_word = word;
    endtask

    task automatic idle_gap(input int g);
        ev_t ev;
        @(negedge clk);
        bclk = 1'b0;
        if (m_locked && g > 4200) begin
            ev.is_err = 1'b1;
            ev.l      = '0;
            ev.r      = '0;
            ev.cyc    = last_rise + 2 + WD_FIRE;
            sb.push_back(ev);
            m_locked = 1'b0;
            m_fresh  = 1'b0;
        end
        repeat (g) @(negedge clk);
    endtask

    task automatic random_slots(input int n, input bit allow_short);
        int len;
        for (int k = 0; k < n; k++) begin
            if (allow_short && $urandom_range(0, 4) == 0) len = $urandom_range(3, AB - 1);
            else                                          len = $urandom_range(AB, 32);
            send_slot(len, $urandom, -1);
        end
    endtask

    // Monitor: every output pulse must match the next expected event, on its exact cycle.
    logic [AB-1:0] shown_l = '0;
    logic [AB-1:0] shown_r = '0;
    logic          prev_valid = 1'b0;
    logic          prev_err = 1'b0;

    always @(negedge clk) begin
        ev_t ev;
        if (!rst_q) begin
            shown_l    = '0;
            shown_r    = '0;
            prev_valid = 1'b0;
            prev_err   = 1'b0;
        end else begin
            if (pcm_valid) begin
                check_val("valid_pulse_len", prev_valid, 0);
                check_val("valid_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    ev = sb.pop_front();
                    check_val("valid_kind_is_err", ev.is_err, 0);
                    check_val("pcm_l", pcm_l, ev.l);
                    check_val("pcm_r", pcm_r, ev.r);
                    check_val("valid_latency", cyc_count, ev.cyc);
                    shown_l = ev.l;
                    shown_r = ev.r;
                end
            end else begin
                check_val("hold_pcm_l", pcm_l, shown_l);
                check_val("hold_pcm_r", pcm_r, shown_r);
            end
            if (frame_err) begin
                check_val("err_pulse_len", prev_err, 0);
                check_val("err_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    ev = sb.pop_front();
                    check_val("err_kind_is_err", ev.is_err, 1);
                    check_val("err_latency", cyc_count, ev.cyc);
                end
            end
            prev_valid = pcm_valid;
            prev_err   = frame_err;
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        check_val("init_pcm_l", pcm_l, 0);
        check_val("init_pcm_r", pcm_r, 0);
        check_val("init_valid", pcm_valid, 0);
        check_val("init_err", frame_err, 0);
        check_val("init_locked", locked, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int f = 0; f < 3; f++) begin
            send_slot(16, {16'h8001, 16'h0000}, -1);
            send_slot(16, {16'h7FFE, 16'h0000}, -1);
        end
        for (int f = 0; f < 2; f++) begin
            send_slot(32, 32'h1234ABCD, -1);
            send_slot(32, 32'hFFFF0000, -1);
        end
        check_val("locked_in_stream", locked, 1);

        // Short left slot inside a locked stream.
        send_slot(10, $urandom, -1);
        send_slot(16, $urandom, -1);
        send_slot(16, $urandom, -1);
        send_slot(16, $urandom, -1);

        random_slots(24, 1'b1);

        idle_gap(5000);
        check_val("locked_after_stall", locked, 0);
        random_slots(8, 1'b0);

        // Reset a few bits into a right slot.
        if (next_ch == 1'b0) send_slot(16, $urandom, -1);
        send_slot(32, $urandom, 4);
        random_slots(8, 1'b0);
        random_slots(12, 1'b1);

        idle_gap(5000);
        check_val("locked_at_end", locked, 0);
        check_val("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
